// File: rtl/shift_arbiter_pkg.sv
// Shared constants for the shift arbiter: FSM encoding, requester IDs and
// datapath widths.
package shift_arbiter_pkg;

   localparam int DATA_W = 32;
   localparam int SA_W   = 5;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_e;

   localparam logic ID_A = 1'b0;
   localparam logic ID_B = 1'b1;

endpackage

// File: rtl/SHIFTER_32.sv
// Combinational 32-bit barrel shifter: zero-filling left shift, right shift
// filled with X[31] when Arith is set.
module SHIFTER_32
   import shift_arbiter_pkg::*;
(
   input  logic [DATA_W-1:0] X,
   input  logic [SA_W-1:0]   Sa,
   input  logic              Arith,
   input  logic              Right,
   output logic [DATA_W-1:0] Sh
);

   logic [DATA_W:0] ext;

   // One extra fill bit on top lets a single arithmetic shift cover both
   // logical and sign-filled right shifts.
   assign ext = {Arith & X[DATA_W-1], X};
   assign Sh  = Right ? DATA_W'($signed(ext) >>> Sa) : (X << Sa);

endmodule

// File: rtl/shift_arbiter.sv
// Two requesters share one barrel shifter through a round-robin arbiter;
// results go into a single-entry output register with valid/ready handshake.
module shift_arbiter
   import shift_arbiter_pkg::*;
#(
   parameter int PRIO_INIT = 0
) (
   input  logic              clk,
   input  logic              clrn,
   input  logic              a_valid,
   output logic              a_ready,
   input  logic [DATA_W-1:0] a_x,
   input  logic [SA_W-1:0]   a_sa,
   input  logic              a_arith,
   input  logic              a_right,
   input  logic              b_valid,
   output logic              b_ready,
   input  logic [DATA_W-1:0] b_x,
   input  logic [SA_W-1:0]   b_sa,
   input  logic              b_arith,
   input  logic              b_right,
   output logic              r_valid,
   input  logic              r_ready,
   output logic [DATA_W-1:0] r_data,
   output logic              r_id,
   output state_e            dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid and ready
   // are both high; ready never depends on the same side's operand values.

   localparam logic LAST_INIT = (PRIO_INIT != 0) ? ID_B : ID_A;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] r_data_q, r_data_d;
   logic              r_id_q, r_id_d;
   logic              last_q, last_d;

   logic              can_accept;
   logic              grant_id;
   logic              accept;
   logic [DATA_W-1:0] sel_x;
   logic [SA_W-1:0]   sel_sa;
   logic              sel_arith;
   logic              sel_right;
   logic [DATA_W-1:0] sh;

   always_comb begin
      can_accept = (state_q == ST_EMPTY) | r_ready;
      // On a tie the requester that was not granted last wins.
      if (a_valid & b_valid) begin
         grant_id = ~last_q;
      end else begin
         grant_id = b_valid ? ID_B : ID_A;
      end
      a_ready = can_accept & a_valid & (grant_id == ID_A);
      b_ready = can_accept & b_valid & (grant_id == ID_B);
      accept  = a_ready | b_ready;
   end

   always_comb begin
      if (grant_id == ID_B) begin
         sel_x     = b_x;
         sel_sa    = b_sa;
         sel_arith = b_arith;
         sel_right = b_right;
      end else begin
         sel_x     = a_x;
         sel_sa    = a_sa;
         sel_arith = a_arith;
         sel_right = a_right;
      end
   end

   SHIFTER_32 u_shifter (
      .X     (sel_x),
      .Sa    (sel_sa),
      .Arith (sel_arith),
      .Right (sel_right),
      .Sh    (sh)
   );

   always_comb begin
      state_d  = state_q;
      r_data_d = r_data_q;
      r_id_d   = r_id_q;
      last_d   = last_q;
      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               state_d  = ST_FULL;
               r_data_d = sh;
               r_id_d   = grant_id;
               last_d   = grant_id;
            end
         end
         ST_FULL: begin
            if (accept) begin
               r_data_d = sh;
               r_id_d   = grant_id;
               last_d   = grant_id;
            end else if (r_ready) begin
               state_d = ST_EMPTY;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q  <= ST_EMPTY;
         r_data_q <= '0;
         r_id_q   <= ID_A;
         last_q   <= LAST_INIT;
      end else begin
         state_q  <= state_d;
         r_data_q <= r_data_d;
         r_id_q   <= r_id_d;
         last_q   <= last_d;
      end
   end

   assign r_valid   = (state_q == ST_FULL);
   assign r_data    = r_data_q;
   assign r_id      = r_id_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed scoreboard bench for shift_arbiter: one instance with PRIO_INIT=0
// and one with PRIO_INIT=1, each with its own expected queue and monitor.
module tb_shift_arbiter;
   import shift_arbiter_pkg::*;

   // clock / reset
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic clrn;

   // instance 0 (PRIO_INIT=0)
   logic        a_valid, a_ready, a_arith, a_right;
   logic [31:0] a_x;
   logic [4:0]  a_sa;
   logic        b_valid, b_ready, b_arith, b_right;
   logic [31:0] b_x;
   logic [4:0]  b_sa;
   logic        r_valid, r_ready, r_id;
   logic [31:0] r_data;
   state_e      dbg_state;

   // instance 1 (PRIO_INIT=1)
   logic        pa_valid, pa_ready, pa_arith, pa_right;
   logic [31:0] pa_x;
   logic [4:0]  pa_sa;
   logic        pb_valid, pb_ready, pb_arith, pb_right;
   logic [31:0] pb_x;
   logic [4:0]  pb_sa;
   logic        pr_valid, pr_ready, pr_id;
   logic [31:0] pr_data;
   state_e      p_dbg_state;

   shift_arbiter #(.PRIO_INIT(0)) dut0 (
      .clk(clk), .clrn(clrn),
      .a_valid(a_valid), .a_ready(a_ready), .a_x(a_x), .a_sa(a_sa),
      .a_arith(a_arith), .a_right(a_right),
      .b_valid(b_valid), .b_ready(b_ready), .b_x(b_x), .b_sa(b_sa),
      .b_arith(b_arith), .b_right(b_right),
      .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_id(r_id),
      .dbg_state(dbg_state)
   );

   shift_arbiter #(.PRIO_INIT(1)) dut1 (
      .clk(clk), .clrn(clrn),
      .a_valid(pa_valid), .a_ready(pa_ready), .a_x(pa_x), .a_sa(pa_sa),
      .a_arith(pa_arith), .a_right(pa_right),
      .b_valid(pb_valid), .b_ready(pb_ready), .b_x(pb_x), .b_sa(pb_sa),
      .b_arith(pb_arith), .b_right(pb_right),
      .r_valid(pr_valid), .r_ready(pr_ready), .r_data(pr_data), .r_id(pr_id),
      .dbg_state(p_dbg_state)
   );

   // scoreboard
   int n_cmp = 0;
   int n_bad = 0;
   logic [32:0] exp_q[$];
   logic [32:0] exp1_q[$];

   task automatic check1(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check33(input string name, input logic [32:0] act, input logic [32:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (clrn && r_valid && r_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL mon0_unexpected: got %h expected nothing", {r_id, r_data});
         end else begin
            check33("mon0_result", {r_id, r_data}, exp_q.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (clrn && pr_valid && pr_ready) begin
         if (exp1_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL mon1_unexpected: got %h expected nothing", {pr_id, pr_data});
         end else begin
            check33("mon1_result", {pr_id, pr_data}, exp1_q.pop_front());
         end
      end
   end

   // driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_a(input logic v, input logic [31:0] x, input logic [4:0] sa,
                        input logic ar, input logic rt);
      a_valid = v; a_x = x; a_sa = sa; a_arith = ar; a_right = rt;
   endtask

   task automatic set_b(input logic v, input logic [31:0] x, input logic [4:0] sa,
                        input logic ar, input logic rt);
      b_valid = v; b_x = x; b_sa = sa; b_arith = ar; b_right = rt;
   endtask

   task automatic set_pa(input logic v, input logic [31:0] x, input logic [4:0] sa,
                         input logic ar, input logic rt);
      pa_valid = v; pa_x = x; pa_sa = sa; pa_arith = ar; pa_right = rt;
   endtask

   task automatic set_pb(input logic v, input logic [31:0] x, input logic [4:0] sa,
                         input logic ar, input logic rt);
      pb_valid = v; pb_x = x; pb_sa = sa; pb_arith = ar; pb_right = rt;
   endtask

   initial begin
      clrn = 1'b0;
      r_ready = 1'b0;
      pr_ready = 1'b0;
      set_a(0, 32'h0, 5'd0, 0, 0);
      set_b(0, 32'h0, 5'd0, 0, 0);
      set_pa(0, 32'h0, 5'd0, 0, 0);
      set_pb(0, 32'h0, 5'd0, 0, 0);
      repeat (3) step();
      check1("rst_r_valid", r_valid, 1'b0);
      check32("rst_r_data", r_data, 32'h0);
      check1("rst_r_id", r_id, 1'b0);
      check1("rst_state", dbg_state, ST_EMPTY);
      check1("rst_p_r_valid", pr_valid, 1'b0);
      clrn = 1'b1;

      // tie on PRIO_INIT=1 instance: A first, then B
      pr_ready = 1'b1;
      set_pa(1, 32'h0000_00FF, 5'd8, 0, 0);
      set_pb(1, 32'hF000_0000, 5'd28, 0, 1);
      #1;
      check1("p1_tie_a_ready", pa_ready, 1'b1);
      check1("p1_tie_b_ready", pb_ready, 1'b0);
      exp1_q.push_back({1'b0, 32'h0000_FF00});
      step();
      set_pa(0, 32'h0, 5'd0, 0, 0);
      #1;
      check1("p1_second_b_ready", pb_ready, 1'b1);
      exp1_q.push_back({1'b1, 32'h0000_000F});
      step();
      set_pb(0, 32'h0, 5'd0, 0, 0);
      repeat (2) step();

      // single A, arithmetic right shift, 1-cycle latency
      r_ready = 1'b1;
      set_a(1, 32'h8000_0001, 5'd4, 1, 1);
      #1;
      check1("single_a_ready", a_ready, 1'b1);
      check1("single_b_ready", b_ready, 1'b0);
      exp_q.push_back({1'b0, 32'hF800_0000});
      step();
      set_a(0, 32'h0, 5'd0, 0, 0);
      #1;
      check1("latency_r_valid", r_valid, 1'b1);
      check32("latency_r_data", r_data, 32'hF800_0000);
      step();
      check1("drain_r_valid", r_valid, 1'b0);

      // left shift ignores arith
      set_a(1, 32'h8000_0000, 5'd1, 1, 0);
      #1;
      check1("left_arith_a_ready", a_ready, 1'b1);
      exp_q.push_back({1'b0, 32'h0000_0000});
      step();
      set_a(0, 32'h0, 5'd0, 0, 0);
      step();

      // single B, right arith with positive operand
      set_b(1, 32'h0000_00F0, 5'd4, 1, 1);
      #1;
      check1("single_b_ready_hi", b_ready, 1'b1);
      exp_q.push_back({1'b1, 32'h0000_000F});
      step();
      set_b(0, 32'h0, 5'd0, 0, 0);
      step();

      // asynchronous reset while FULL discards the held result
      r_ready = 1'b0;
      set_b(1, 32'h0000_1234, 5'd0, 0, 0);
      step();
      set_b(0, 32'h0, 5'd0, 0, 0);
      #1;
      check1("midfull_r_valid", r_valid, 1'b1);
      #1;
      clrn = 1'b0;
      #1;
      check1("async_rst_r_valid", r_valid, 1'b0);
      check32("async_rst_r_data", r_data, 32'h0);
      check1("async_rst_r_id", r_id, 1'b0);
      check1("async_rst_state", dbg_state, ST_EMPTY);
      repeat (2) step();
      clrn = 1'b1;
      r_ready = 1'b1;

      // tie after reset with PRIO_INIT=0: B first
      set_a(1, 32'h0000_0001, 5'd1, 0, 0);
      set_b(1, 32'h0000_0010, 5'd4, 0, 1);
      #1;
      check1("rst_tie_b_ready", b_ready, 1'b1);
      check1("rst_tie_a_ready", a_ready, 1'b0);
      exp_q.push_back({1'b1, 32'h0000_0001});
      step();
      set_b(0, 32'h0, 5'd0, 0, 0);
      #1;
      check1("rst_tie_then_a", a_ready, 1'b1);
      exp_q.push_back({1'b0, 32'h0000_0002});
      step();
      set_a(0, 32'h0, 5'd0, 0, 0);
      step();

      // backpressure: FULL with r_ready low holds data and blocks both
      r_ready = 1'b0;
      set_a(1, 32'hFFFF_0000, 5'd16, 1, 1);
      set_b(1, 32'h0000_000F, 5'd31, 0, 0);
      #1;
      check1("bp_first_b_ready", b_ready, 1'b1);
      exp_q.push_back({1'b1, 32'h8000_0000});
      step();
      set_b(1, 32'h0000_0003, 5'd1, 0, 0);
      for (int i = 0; i < 3; i++) begin
         #1;
         check1("bp_a_ready", a_ready, 1'b0);
         check1("bp_b_ready", b_ready, 1'b0);
         check1("bp_r_valid", r_valid, 1'b1);
         check32("bp_r_data", r_data, 32'h8000_0000);
         step();
      end
      r_ready = 1'b1;
      #1;
      check1("bp_release_a_ready", a_ready, 1'b1);
      check1("bp_release_b_ready", b_ready, 1'b0);
      exp_q.push_back({1'b0, 32'hFFFF_FFFF});
      step();
      set_a(0, 32'h0, 5'd0, 0, 0);
      #1;
      check1("bp_then_b_ready", b_ready, 1'b1);
      exp_q.push_back({1'b1, 32'h0000_0006});
      step();
      set_b(0, 32'h0, 5'd0, 0, 0);
      step();

      // streaming: both valid, one result per cycle, ids alternate
      set_a(1, 32'hDEAD_BEEF, 5'd0, 1, 1);
      set_b(1, 32'h1234_5678, 5'd0, 0, 0);
      #1;
      check1("stream0_a_ready", a_ready, 1'b1);
      exp_q.push_back({1'b0, 32'hDEAD_BEEF});
      step();
      set_a(1, 32'hA5A5_A5A5, 5'd0, 0, 0);
      #1;
      check1("stream1_b_ready", b_ready, 1'b1);
      exp_q.push_back({1'b1, 32'h1234_5678});
      step();
      set_b(1, 32'h8000_0000, 5'd31, 1, 1);
      #1;
      check1("stream2_a_ready", a_ready, 1'b1);
      exp_q.push_back({1'b0, 32'hA5A5_A5A5});
      step();
      set_a(1, 32'h0F0F_0F0F, 5'd4, 0, 0);
      #1;
      check1("stream3_b_ready", b_ready, 1'b1);
      check1("stream3_a_blocked", a_ready, 1'b0);
      exp_q.push_back({1'b1, 32'hFFFF_FFFF});
      step();
      set_b(0, 32'h0, 5'd0, 0, 0);
      #1;
      check1("stream4_a_ready", a_ready, 1'b1);
      exp_q.push_back({1'b0, 32'hF0F0_F0F0});
      step();
      set_a(0, 32'h0, 5'd0, 0, 0);
      repeat (4) step();

      check32("exp_q_drained", 32'(exp_q.size()), 32'd0);
      check32("exp1_q_drained", 32'(exp1_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
